// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int UART_CLK_DIV_DEFAULT = 103;
    localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high serial line.
// Both stages reset to 1 so a reset never looks like a start edge by itself.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] stage_reg;

    // Shift the raw line through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_reg <= 2'b11;
        end else begin
            stage_reg <= {stage_reg[0], d};
        end
    end

    assign q = stage_reg[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the line, validates the start bit at
// half a bit period, samples each data bit mid-bit and hands bytes over
// through a VALID/READY holding register with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = UART_CLK_DIV_DEFAULT,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_BITS);

    // Half a bit from the detected edge lands the start sample mid-bit;
    // every later sample is one full bit further on.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    uart_rx_state_t       state_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 busy_reg;
    logic                 frame_err_reg;
    logic                 deliver_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 overrun_reg;
    logic                 tick;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // A sample point is due whenever the bit timer has run out while a frame is in progress.
    assign tick = (state_reg != IDLE) && (count_reg == '0);

    // Frame state machine: bit timer, shifter, bit counter and the stop-bit verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            busy_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            deliver_reg   <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            deliver_reg   <= 1'b0;

            if ((state_reg != IDLE) && (count_reg != '0)) begin
                count_reg <= count_reg - CNT_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (!rx_s) begin
                        state_reg <= START;
                        count_reg <= HALF_LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rx_s) begin
                            state_reg   <= DATA;
                            count_reg   <= FULL_LOAD;
                            bit_idx_reg <= '0;
                        end else begin
                            // Line went back high before mid start bit: a glitch, not a frame.
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg   <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        count_reg   <= FULL_LOAD;
                        bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        if (bit_idx_reg == LAST_IDX) begin
                            state_reg <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            // Returning to IDLE here, mid stop bit, lets a back-to-back start be seen.
                            deliver_reg <= 1'b1;
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Wait out a held-low line so a break reports only one framing error.
                    if (rx_s) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: load a finished byte unless an unaccepted one is still there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (deliver_reg) begin
                if (!valid_reg || ready) begin
                    data_reg  <= shift_reg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign busy      = busy_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus serialises bytes onto the line and
// queues the bytes it expects; an independent monitor pops and compares on
// every VALID&READY handshake and tallies error pulses.
module tb_uart_rx;

    localparam int BIT = 103;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    uart_rx #(.CLK_DIV(BIT), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    logic [7:0]  exp_q[$];
    int          fe_seen = 0, ov_seen = 0, exp_fe = 0, exp_ov = 0;
    int          valid_cycles = 0;
    int unsigned accept_cyc = 0, fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model of the line: bit 0 start (low), bits 1..8 the byte LSB first, bit 9 stop.
    function automatic logic line_bit(input logic [7:0] b, input int i, input logic stop_val);
        if (i == 0) return 1'b0;
        if (i <= 8) return 1'(int'(b) / (1 << (i - 1)) % 2);
        return stop_val;
    endfunction

    task automatic send_frame(input logic [7:0] b, input int bit_cyc, input logic stop_val);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            rx = line_bit(b, i, stop_val);
            if (i == 0) fall_cyc = cyc;
            repeat (bit_cyc - 1) @(posedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int bit_cyc);
        exp_q.push_back(b);
        send_frame(b, bit_cyc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: compare each accepted byte, check hold stability, count error pulses.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (valid) valid_cycles++;
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            if (prev_hold && valid) check("hold_stable", data, prev_data);
            if (valid && ready) begin
                accept_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte actual=%02h required=none", data);
                end else begin
                    exp_b = exp_q.pop_front();
                    $display("rx byte %02h expected %02h at cycle %0d", data, exp_b, cyc);
                    check("rx_byte", data, exp_b);
                end
            end
            prev_hold = valid && !ready;
            prev_data = data;
        end
    end

    initial begin
        #900000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        string       msg;
        int          v0;
        logic [7:0]  rb;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_fe", frame_err, 0);
        check("rst_ov", overrun, 0);
        rst_n = 1'b1;
        idle(20);

        // 1: single byte, latency and single VALID cycle
        v0 = valid_cycles;
        send_byte(8'h55, BIT);
        idle(20);
        check_range("latency", int'(accept_cyc - fall_cyc), 982, 984);
        check("single_valid", valid_cycles - v0, 1);
        check("t1_fe", fe_seen, exp_fe);
        check("t1_ov", ov_seen, exp_ov);
        drain("t1_drain");

        // 2: overrun while holding register is full
        ready = 1'b0;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, BIT, 1'b1);
        send_frame(8'h0F, BIT, 1'b1);
        exp_ov++;
        idle(5);
        check("t2_valid_held", valid, 1);
        check("t2_data_held", data, 8'hA3);
        check("t2_ov", ov_seen, exp_ov);
        ready = 1'b1;
        @(posedge clk); #1;
        check("t2_valid_fall", valid, 0);
        drain("t2_drain");

        // 3: short glitch aborts in START
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("t3_busy_during", busy, 1);
        rx = 1'b1;
        idle(100);
        check("t3_valid", valid, 0);
        check("t3_busy", busy, 0);
        check("t3_fe", fe_seen, exp_fe);

        // 4: framing error followed by a long break, then a clean byte
        send_frame(8'h81, BIT, 1'b0);
        exp_fe++;
        repeat (2000) @(posedge clk);
        #1;
        check("t4_busy_break", busy, 1);
        rx = 1'b1;
        idle(300);
        check("t4_fe", fe_seen, exp_fe);
        check("t4_valid", valid, 0);
        check("t4_busy", busy, 0);
        send_byte(8'h3C, BIT);
        drain("t4_drain");

        // 5: reset during data bit 4 of 0xFF
        @(posedge clk); #1;
        rx = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (4 * BIT + 50) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        check("t5_rst_data", data, 0);
        check("t5_rst_valid", valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ov", overrun, 0);
        idle(5);
        rst_n = 1'b1;
        idle(200);
        check("t5_idle_busy", busy, 0);
        send_byte(8'h12, BIT);
        drain("t5_drain");

        // 6: loopback string at +3% baud period, random bytes at -3% and nominal
        msg = "Hello, icestick!";
        for (int i = 0; i < 16; i++) send_byte(msg[i], 106);
        drain("t6_plus3");
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_byte(rb, 100);
        end
        drain("t6_minus3");
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom_range(0, 255));
            send_byte(rb, BIT);
            idle($urandom_range(0, 50));
        end
        drain("t6_nominal");
        check("t6_fe", fe_seen, exp_fe);
        check("t6_ov", ov_seen, exp_ov);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
